// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed RAM with byte-lane writes plus a
// 16-byte register window (64-bit cycle counter, GPIO, TOHOST halt mailbox).
// Reads are combinational; all state changes happen on the rising clock edge.

`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef MASK_WIDTH
`define MASK_WIDTH 4
`endif

module dmem_responder #(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [`MEM_ADDR_WIDTH-1:0]  dram_addr,
    input  logic [`REG_DATA_WIDTH-1:0]  dram_wr_data,
    input  logic                        dram_wr_en,
    input  logic                        dram_rd_en,
    input  logic [`MASK_WIDTH-1:0]      dram_mask,
    output logic [`REG_DATA_WIDTH-1:0]  dram_rd_data,
    output logic [31:0]                 gpio_out,
    output logic                        halt,
    output logic [31:0]                 halt_code,
    output logic                        bus_err
);

    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

    // Word addresses (byte address >> 2) of the four window registers.
    localparam logic [29:0] CNT_LO_W = MMIO_BASE[31:2];
    localparam logic [29:0] CNT_HI_W = CNT_LO_W + 30'd1;
    localparam logic [29:0] GPIO_W   = CNT_LO_W + 30'd2;
    localparam logic [29:0] TOHOST_W = CNT_LO_W + 30'd3;

    // Replace only the byte lanes whose mask bit is set.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  mask);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [63:0] cnt_q,       cnt_d;
    logic [31:0] gpio_q,      gpio_d;
    logic [31:0] tohost_q,    tohost_d;
    logic        halt_q,      halt_d;
    logic [31:0] halt_code_q, halt_code_d;
    logic        bus_err_q,   bus_err_d;

    logic             is_ram, is_cnt_lo, is_cnt_hi, is_gpio, is_tohost, is_mapped;
    logic [IDX_W-1:0] ram_idx;
    logic [31:0]      tohost_merged;

    // Address decode shared by the read mux and the write path.
    always_comb begin
        is_ram    = {1'b0, dram_addr} < RAM_BYTES;
        is_cnt_lo = dram_addr[31:2] == CNT_LO_W;
        is_cnt_hi = dram_addr[31:2] == CNT_HI_W;
        is_gpio   = dram_addr[31:2] == GPIO_W;
        is_tohost = dram_addr[31:2] == TOHOST_W;
        is_mapped = is_ram | is_cnt_lo | is_cnt_hi | is_gpio | is_tohost;
        ram_idx   = dram_addr[IDX_W+1:2];
    end

    // Combinational read mux; idle, unmapped and in-reset reads return zero.
    always_comb begin
        dram_rd_data = '0;
        if (dram_rd_en && !rst) begin
            if (is_ram)         dram_rd_data = mem_q[ram_idx];
            else if (is_cnt_lo) dram_rd_data = cnt_q[31:0];
            else if (is_cnt_hi) dram_rd_data = cnt_q[63:32];
            else if (is_gpio)   dram_rd_data = gpio_q;
            else if (is_tohost) dram_rd_data = tohost_q;
        end
    end

    // Next-state for the register window, counter and error flag.
    always_comb begin
        cnt_d         = halt_q ? cnt_q : cnt_q + 64'd1;
        gpio_d        = gpio_q;
        tohost_d      = tohost_q;
        halt_d        = halt_q;
        halt_code_d   = halt_code_q;
        bus_err_d     = bus_err_q;
        tohost_merged = lane_merge(tohost_q, dram_wr_data, dram_mask);

        if (dram_wr_en && is_gpio)
            gpio_d = lane_merge(gpio_q, dram_wr_data, dram_mask);

        // Once halted the mailbox is frozen until reset.
        if (dram_wr_en && is_tohost && !halt_q) begin
            tohost_d = tohost_merged;
            if (tohost_merged != 32'd0) begin
                halt_d      = 1'b1;
                halt_code_d = tohost_merged;
            end
        end

        if ((dram_rd_en || dram_wr_en) && !is_mapped)
            bus_err_d = 1'b1;
    end

    // Register window state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            gpio_q      <= '0;
            tohost_q    <= '0;
            halt_q      <= 1'b0;
            halt_code_q <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            gpio_q      <= gpio_d;
            tohost_q    <= tohost_d;
            halt_q      <= halt_d;
            halt_code_q <= halt_code_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // RAM byte-lane writes.
    // NOTE: the RAM array has no reset so it maps onto block RAM; reset only
    // suppresses the write, and contents survive it.
    always_ff @(posedge clk) begin
        if (!rst && dram_wr_en && is_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (dram_mask[i]) mem_q[ram_idx][8*i +: 8] <= dram_wr_data[8*i +: 8];
            end
        end
    end

    assign gpio_out  = gpio_q;
    assign halt      = halt_q;
    assign halt_code = halt_code_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: byte lanes, read-during-write, counter
// start/wrap/freeze, halt mailbox, unmapped access and reset behaviour.

module tb_dmem_responder;

    localparam logic [31:0] BASE   = 32'h1000_0000;
    localparam logic [31:0] CNT_LO = BASE + 32'h0;
    localparam logic [31:0] CNT_HI = BASE + 32'h4;
    localparam logic [31:0] GPIO   = BASE + 32'h8;
    localparam logic [31:0] TOHOST = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dram_addr;
    logic [31:0] dram_wr_data;
    logic        dram_wr_en;
    logic        dram_rd_en;
    logic [3:0]  dram_mask;
    logic [31:0] dram_rd_data;
    logic [31:0] gpio_out;
    logic        halt;
    logic [31:0] halt_code;
    logic        bus_err;

    int checks   = 0;
    int failures = 0;
    logic [31:0] rd;

    dmem_responder #(.DEPTH_WORDS(4096), .MMIO_BASE(BASE)) dut (
        .clk          (clk),
        .rst          (rst),
        .dram_addr    (dram_addr),
        .dram_wr_data (dram_wr_data),
        .dram_wr_en   (dram_wr_en),
        .dram_rd_en   (dram_rd_en),
        .dram_mask    (dram_mask),
        .dram_rd_data (dram_rd_data),
        .gpio_out     (gpio_out),
        .halt         (halt),
        .halt_code    (halt_code),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One write, committed on the next rising edge; returns 1 ns after it.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        dram_addr    = a;
        dram_wr_data = d;
        dram_mask    = m;
        dram_wr_en   = 1'b1;
        @(posedge clk);
        #1;
        dram_wr_en   = 1'b0;
    endtask

    // Combinational read, sampled without crossing a clock edge.
    task automatic rd_now(input logic [31:0] a, output logic [31:0] d);
        dram_addr  = a;
        dram_rd_en = 1'b1;
        #1;
        d = dram_rd_data;
        dram_rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; dram_addr = '0; dram_wr_data = '0;
        dram_wr_en = 1'b0; dram_rd_en = 1'b0; dram_mask = '0;

        // Reset state; a RAM read while in reset returns 0.
        repeat (2) @(posedge clk);
        #1;
        rd_now(32'h40, rd);            check("rd_in_reset", rd, 32'h0);
        check("gpio_reset",      gpio_out,          32'h0);
        check("halt_reset",      {31'd0, halt},     32'h0);
        check("halt_code_reset", halt_code,         32'h0);
        check("bus_err_reset",   {31'd0, bus_err},  32'h0);

        // Counter reads 0 right after release, 1 after the first edge.
        @(negedge clk); rst = 1'b0;
        rd_now(CNT_LO, rd);            check("cnt_start0", rd, 32'h0);
        @(posedge clk); #1;
        rd_now(CNT_LO, rd);            check("cnt_start1", rd, 32'h1);

        // Byte-lane writes, and a zero mask changes nothing.
        wr(32'h40, 32'hAABB_CCDD, 4'b1111);
        wr(32'h40, 32'h0000_1100, 4'b0010);
        rd_now(32'h40, rd);            check("byte_lane", rd, 32'hAABB_11DD);
        wr(32'h40, 32'hFFFF_FFFF, 4'b0000);
        rd_now(32'h40, rd);            check("mask_zero", rd, 32'hAABB_11DD);
        dram_addr = 32'h40; #1;        check("rd_en_low", dram_rd_data, 32'h0);

        // Read-during-write returns the old word, new word next cycle.
        wr(32'h80, 32'h5, 4'b1111);
        @(negedge clk);
        dram_addr = 32'h80; dram_wr_data = 32'h9; dram_mask = 4'b1111;
        dram_wr_en = 1'b1; dram_rd_en = 1'b1;
        #1;                            check("rdw_old", dram_rd_data, 32'h5);
        @(posedge clk); #1;
        dram_wr_en = 1'b0;
        #1;                            check("rdw_new", dram_rd_data, 32'h9);
        dram_rd_en = 1'b0;

        // GPIO masking; RAM write at a low address leaves GPIO alone.
        wr(GPIO, 32'h1234_5678, 4'b1111);
        wr(GPIO, 32'h0000_00FF, 4'b0001);
        check("gpio_out", gpio_out, 32'h1234_56FF);
        rd_now(GPIO, rd);              check("gpio_read", rd, 32'h1234_56FF);
        wr(32'h8, 32'hDEAD_BEEF, 4'b1111);
        check("gpio_isolated", gpio_out, 32'h1234_56FF);
        rd_now(32'h8, rd);             check("ram_low", rd, 32'hDEAD_BEEF);

        // Counter registers ignore writes and do not raise bus_err.
        wr(CNT_HI, 32'hFFFF_FFFF, 4'b1111);
        rd_now(CNT_HI, rd);            check("cnt_hi_ro", rd, 32'h0);
        check("cnt_wr_no_err", {31'd0, bus_err}, 32'h0);

        // Counter wrap: preload 0xFFFF_FFFF_FFFF_FFFE, then two edges.
        @(negedge clk);
        force dut.cnt_q = 64'hFFFF_FFFF_FFFF_FFFE;
        #1;
        release dut.cnt_q;
        rd_now(CNT_LO, rd);            check("wrap_pre_lo", rd, 32'hFFFF_FFFE);
        rd_now(CNT_HI, rd);            check("wrap_pre_hi", rd, 32'hFFFF_FFFF);
        repeat (2) @(posedge clk);
        #1;
        rd_now(CNT_LO, rd);            check("wrap_lo", rd, 32'h0);
        rd_now(CNT_HI, rd);            check("wrap_hi", rd, 32'h0);

        // Zero TOHOST write: register updates, no halt (counter -> 1).
        wr(TOHOST, 32'h0, 4'b1111);
        check("tohost0_no_halt", {31'd0, halt}, 32'h0);
        // Nonzero write halts; the counter still advances on that edge (-> 2).
        wr(TOHOST, 32'h1, 4'b1111);
        check("halt_set",  {31'd0, halt}, 32'h1);
        check("halt_code", halt_code,     32'h1);
        repeat (3) @(posedge clk);
        #1;
        rd_now(CNT_LO, rd);            check("cnt_frozen", rd, 32'h2);
        wr(TOHOST, 32'h7, 4'b1111);
        check("halt_code_kept", halt_code, 32'h1);
        rd_now(TOHOST, rd);            check("tohost_kept", rd, 32'h1);

        // Unmapped read: data 0, bus_err on the following edge, sticky.
        @(negedge clk);
        dram_addr = BASE + 32'h10; dram_rd_en = 1'b1;
        #1;                            check("unmapped_rd", dram_rd_data, 32'h0);
        check("bus_err_before", {31'd0, bus_err}, 32'h0);
        @(posedge clk); #1;
        dram_rd_en = 1'b0;
        check("bus_err_set", {31'd0, bus_err}, 32'h1);
        repeat (3) @(posedge clk);
        #1;                            check("bus_err_sticky", {31'd0, bus_err}, 32'h1);

        // Reset during a GPIO write: write discarded, state cleared.
        @(negedge clk);
        rst = 1'b1;
        dram_addr = GPIO; dram_wr_data = 32'hFF; dram_mask = 4'b1111; dram_wr_en = 1'b1;
        @(posedge clk); #1;
        check("rst_gpio",      gpio_out,          32'h0);
        check("rst_halt",      {31'd0, halt},     32'h0);
        check("rst_halt_code", halt_code,         32'h0);
        check("rst_bus_err",   {31'd0, bus_err},  32'h0);
        // RAM write during reset is discarded too.
        @(negedge clk);
        dram_addr = 32'h80; dram_wr_data = 32'h77;
        @(posedge clk); #1;
        dram_wr_en = 1'b0;
        @(negedge clk); rst = 1'b0;
        rd_now(32'h40, rd);            check("ram_kept_40", rd, 32'hAABB_11DD);
        rd_now(32'h80, rd);            check("ram_kept_80", rd, 32'h9);
        rd_now(CNT_LO, rd);            check("cnt_after_rst", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
